hazard_scoreboard: RTL and testbench

- Parametrised hazard, forwarding and pipeline-control unit for the in-order RISC-V pipeline; replaces fixed 5-stage hazard logic.
- Keeps a shift-register scoreboard of in-flight instructions from EX to the last stage, and drives stall, flush and freeze for IF/ID/EX.
- Generates per-operand forwarding selects for EX, with depth-aware load-use interlocks.
- Counts stall and flush events for performance monitoring.

---
 rtl/hazard_scoreboard_pkg.sv | 39 +++
 rtl/hazard_scoreboard_if.sv | 47 ++++
 rtl/hazard_scoreboard_sat_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_pkg
//  Brief    : Shared types and helpers for the hazard/forwarding scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   localparam int SB_REG_ADDR_W = 8;
   localparam int SB_FWD_SEL_W  = 8;

   typedef logic [SB_REG_ADDR_W-1:0] sb_reg_t;
   typedef logic [SB_FWD_SEL_W-1:0]  fwd_sel_t;

   typedef struct packed {
      logic    valid;
      sb_reg_t rd;
      sb_reg_t rs1;
      sb_reg_t rs2;
      logic    use_rs1;
      logic    use_rs2;
      logic    reg_write;
      logic    is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      CTL_RUN      = 2'd0,
      CTL_FREEZE   = 2'd1,
      CTL_REDIRECT = 2'd2,
      CTL_LOAD_USE = 2'd3
   } ctl_mode_t;

   // x0 is hard-wired, so a write to it never produces a value.
   function automatic logic writes_reg(sb_entry_t e, sb_reg_t src);
      return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard_if
//  Brief    : Decode/control bundle between the pipeline and the hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
   parameter int NUM_STAGES = 5,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_SEL_W  = $clog2(NUM_STAGES),
   parameter int COUNT_W    = 16
);
   logic                  dec_valid;
   logic [REG_ADDR_W-1:0] dec_rs1;
   logic [REG_ADDR_W-1:0] dec_rs2;
   logic                  dec_use_rs1;
   logic                  dec_use_rs2;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic                  dec_reg_write;
   logic                  dec_is_load;
   logic                  ex_redirect;
   logic                  mem_stall;
   logic                  freeze;
   logic                  stall_f;
   logic                  stall_d;
   logic                  flush_d;
   logic                  flush_e;
   logic [FWD_SEL_W-1:0]  fwd_a_sel;
   logic [FWD_SEL_W-1:0]  fwd_b_sel;
   logic [COUNT_W-1:0]    stall_cycles;
   logic [COUNT_W-1:0]    flush_count;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_rd, dec_reg_write, dec_is_load, ex_redirect, mem_stall,
      input  freeze, stall_f, stall_d, flush_d, flush_e,
             fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_rd, dec_reg_write, dec_is_load, ex_redirect, mem_stall,
      output freeze, stall_f, stall_d, flush_d, flush_e,
             fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
   );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at all-ones; synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clear_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Brief    : Depth-parametrised hazard, forwarding and stall/flush control.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_STAGES       = 5,
   parameter int EX_STAGE         = 2,
   parameter int LOAD_READY_STAGE = 4,
   parameter int REG_ADDR_W       = 5,
   parameter int FWD_SEL_W        = $clog2(NUM_STAGES),
   parameter int COUNT_W          = 16
) (
   input  logic                clk,
   input  logic                reset,
   hazard_scoreboard_if.slave  bus
);
   localparam int LAST = NUM_STAGES - 1;

   if (!((EX_STAGE >= 1) && (EX_STAGE < LOAD_READY_STAGE) && (LOAD_READY_STAGE <= LAST)))
   begin : g_bad_stage_order
      $error("hazard_scoreboard: need 1 <= EX_STAGE < LOAD_READY_STAGE <= NUM_STAGES-1");
   end
   if ((REG_ADDR_W > SB_REG_ADDR_W) || (FWD_SEL_W < $clog2(NUM_STAGES)))
   begin : g_bad_widths
      $error("hazard_scoreboard: REG_ADDR_W too wide or FWD_SEL_W too narrow");
   end

   sb_entry_t            entry_q [EX_STAGE:LAST];
   sb_entry_t            entry_d [EX_STAGE:LAST];
   sb_entry_t            dec_entry;
   logic                 load_use;
   ctl_mode_t            mode;
   logic [FWD_SEL_W-1:0] fwd_a;
   logic [FWD_SEL_W-1:0] fwd_b;

   always_comb begin
      dec_entry           = '0;
      dec_entry.valid     = bus.dec_valid;
      dec_entry.rd        = sb_reg_t'(bus.dec_rd);
      dec_entry.rs1       = sb_reg_t'(bus.dec_rs1);
      dec_entry.rs2       = sb_reg_t'(bus.dec_rs2);
      dec_entry.use_rs1   = bus.dec_use_rs1;
      dec_entry.use_rs2   = bus.dec_use_rs2;
      dec_entry.reg_write = bus.dec_reg_write;
      dec_entry.is_load   = bus.dec_is_load;
   end

   // A load still short of LOAD_READY_STAGE one cycle from now cannot feed EX.
   always_comb begin
      load_use = 1'b0;
      for (int s = EX_STAGE; s <= LAST; s++) begin
         if (dec_entry.valid && entry_q[s].is_load && (s + 1 < LOAD_READY_STAGE) &&
             ((dec_entry.use_rs1 && writes_reg(entry_q[s], dec_entry.rs1)) ||
              (dec_entry.use_rs2 && writes_reg(entry_q[s], dec_entry.rs2)))) begin
            load_use = 1'b1;
         end
      end
   end

   always_comb begin
      mode = CTL_RUN;
      if (bus.mem_stall) begin
         mode = CTL_FREEZE;
      end else if (bus.ex_redirect) begin
         mode = CTL_REDIRECT;
      end else if (load_use) begin
         mode = CTL_LOAD_USE;
      end
   end

   always_comb begin
      bus.freeze  = 1'b0;
      bus.stall_f = 1'b0;
      bus.stall_d = 1'b0;
      bus.flush_d = 1'b0;
      bus.flush_e = 1'b0;
      case (mode)
         CTL_FREEZE: begin
            bus.freeze  = 1'b1;
            bus.stall_f = 1'b1;
            bus.stall_d = 1'b1;
         end
         CTL_REDIRECT: begin
            bus.flush_d = 1'b1;
            bus.flush_e = 1'b1;
         end
         CTL_LOAD_USE: begin
            bus.stall_f = 1'b1;
            bus.stall_d = 1'b1;
            bus.flush_e = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int s = EX_STAGE; s <= LAST; s++) begin
         entry_d[s] = entry_q[s];
      end
      if (mode != CTL_FREEZE) begin
         for (int s = EX_STAGE + 1; s <= LAST; s++) begin
            entry_d[s] = entry_q[s-1];
         end
         entry_d[EX_STAGE] = (mode == CTL_RUN) ? dec_entry : '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int s = EX_STAGE; s <= LAST; s++) begin
         if (reset) begin
            entry_q[s] <= '0;
         end else begin
            entry_q[s] <= entry_d[s];
         end
      end
   end

   // Scan oldest to youngest so the nearest producer overwrites the select.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      if (entry_q[EX_STAGE].valid) begin
         for (int k = LAST - EX_STAGE; k >= 1; k--) begin
            if (!entry_q[EX_STAGE+k].is_load || (EX_STAGE + k >= LOAD_READY_STAGE)) begin
               if (entry_q[EX_STAGE].use_rs1 &&
                   writes_reg(entry_q[EX_STAGE+k], entry_q[EX_STAGE].rs1)) begin
                  fwd_a = FWD_SEL_W'(k);
               end
               if (entry_q[EX_STAGE].use_rs2 &&
                   writes_reg(entry_q[EX_STAGE+k], entry_q[EX_STAGE].rs2)) begin
                  fwd_b = FWD_SEL_W'(k);
               end
            end
         end
      end
   end

   assign bus.fwd_a_sel = fwd_a;
   assign bus.fwd_b_sel = fwd_b;

   sat_counter #(.WIDTH(COUNT_W)) u_stall_cnt (
      .clk     (clk),
      .clear_i (reset),
      .inc_i   (bus.stall_d),
      .count_o (bus.stall_cycles)
   );

   sat_counter #(.WIDTH(COUNT_W)) u_flush_cnt (
      .clk     (clk),
      .clear_i (reset),
      .inc_i   (bus.flush_d),
      .count_o (bus.flush_count)
   );
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Brief    : Self-checking bench: default 5-stage unit and a 7-stage variant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       rw;
      logic       ld;
      logic       redir;
      logic       ms;
   } stim_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   stim_t       stq[$];
   logic [10:0] exp_q[$];

   hazard_scoreboard_if #(.NUM_STAGES(5), .REG_ADDR_W(5), .FWD_SEL_W(3), .COUNT_W(16)) ifa ();
   hazard_scoreboard_if #(.NUM_STAGES(7), .REG_ADDR_W(5), .FWD_SEL_W(3), .COUNT_W(2))  ifb ();

   hazard_scoreboard #(
      .NUM_STAGES(5), .EX_STAGE(2), .LOAD_READY_STAGE(4),
      .REG_ADDR_W(5), .FWD_SEL_W(3), .COUNT_W(16)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   hazard_scoreboard #(
      .NUM_STAGES(7), .EX_STAGE(2), .LOAD_READY_STAGE(6),
      .REG_ADDR_W(5), .FWD_SEL_W(3), .COUNT_W(2)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t NOP();
      return '0;
   endfunction

   function automatic stim_t R(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      stim_t s = '0;
      s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
      s.u1 = 1'b1; s.u2 = 1'b1; s.rw = 1'b1;
      return s;
   endfunction

   function automatic stim_t I(logic [4:0] rd, logic [4:0] rs1);
      stim_t s = '0;
      s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.u1 = 1'b1; s.rw = 1'b1;
      return s;
   endfunction

   function automatic stim_t LW(logic [4:0] rd, logic [4:0] rs1);
      stim_t s = I(rd, rs1);
      s.ld = 1'b1;
      return s;
   endfunction

   function automatic stim_t WITH(stim_t s, logic redir, logic ms);
      stim_t t = s;
      t.redir = redir; t.ms = ms;
      return t;
   endfunction

   function automatic logic [10:0] E(logic fr, logic sf, logic sd, logic fd, logic fe,
                                     int fa, int fb);
      return {fr, sf, sd, fd, fe, 3'(fa), 3'(fb)};
   endfunction

   function automatic logic [10:0] got_a();
      return {ifa.freeze, ifa.stall_f, ifa.stall_d, ifa.flush_d, ifa.flush_e,
              ifa.fwd_a_sel, ifa.fwd_b_sel};
   endfunction

   function automatic logic [10:0] got_b();
      return {ifb.freeze, ifb.stall_f, ifb.stall_d, ifb.flush_d, ifb.flush_e,
              ifb.fwd_a_sel, ifb.fwd_b_sel};
   endfunction

   task automatic drive_a(stim_t s);
      ifa.dec_valid = s.valid; ifa.dec_rd = s.rd; ifa.dec_rs1 = s.rs1; ifa.dec_rs2 = s.rs2;
      ifa.dec_use_rs1 = s.u1; ifa.dec_use_rs2 = s.u2; ifa.dec_reg_write = s.rw;
      ifa.dec_is_load = s.ld; ifa.ex_redirect = s.redir; ifa.mem_stall = s.ms;
   endtask

   task automatic drive_b(stim_t s);
      ifb.dec_valid = s.valid; ifb.dec_rd = s.rd; ifb.dec_rs1 = s.rs1; ifb.dec_rs2 = s.rs2;
      ifb.dec_use_rs1 = s.u1; ifb.dec_use_rs2 = s.u2; ifb.dec_reg_write = s.rw;
      ifb.dec_is_load = s.ld; ifb.ex_redirect = s.redir; ifb.mem_stall = s.ms;
   endtask

   task automatic add(stim_t s, logic [10:0] e);
      stq.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      drive_a(NOP());
      drive_b(NOP());
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_tests++; if (got_a() !== 11'd0) begin n_fail++; $display("FAIL reset_ctl_a got=%b exp=%b", got_a(), 11'd0); end
      n_tests++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall_a got=%0d exp=0", ifa.stall_cycles); end
      n_tests++; if (ifa.flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_flush_a got=%0d exp=0", ifa.flush_count); end
      n_tests++; if (got_b() !== 11'd0) begin n_fail++; $display("FAIL reset_ctl_b got=%b exp=%b", got_b(), 11'd0); end
      n_tests++; if (ifb.stall_cycles !== 2'd0) begin n_fail++; $display("FAIL reset_stall_b got=%0d exp=0", ifb.stall_cycles); end
      n_tests++; if (ifb.flush_count !== 2'd0) begin n_fail++; $display("FAIL reset_flush_b got=%0d exp=0", ifb.flush_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(LW(5, 1),    E(0,0,0,0,0,0,0));
      add(R(6, 5, 7),  E(0,1,1,0,1,0,0));
      add(R(6, 5, 7),  E(0,0,0,0,0,0,0));
      add(NOP(),       E(0,0,0,0,0,2,0));
      while (stq.size() > 0) begin
         drive_a(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_a() !== e) begin n_fail++; $display("FAIL load_use cyc%0d got=%b exp=%b", cyc, got_a(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifa.stall_cycles !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt got=%0d exp=1", ifa.stall_cycles); end
      n_tests++; if (ifa.flush_count !== 16'd0) begin n_fail++; $display("FAIL load_use_flush_cnt got=%0d exp=0", ifa.flush_count); end
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(R(3, 1, 2), E(0,0,0,0,0,0,0));
      add(R(3, 3, 4), E(0,0,0,0,0,0,0));
      add(R(8, 3, 3), E(0,0,0,0,0,1,0));
      add(NOP(),      E(0,0,0,0,0,1,1));
      while (stq.size() > 0) begin
         drive_a(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_a() !== e) begin n_fail++; $display("FAIL back_to_back cyc%0d got=%b exp=%b", cyc, got_a(), e); end
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic test_x0();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(I(0, 0),    E(0,0,0,0,0,0,0));
      add(R(9, 0, 0), E(0,0,0,0,0,0,0));
      add(NOP(),      E(0,0,0,0,0,0,0));
      add(LW(0, 0),   E(0,0,0,0,0,0,0));
      add(R(9, 0, 0), E(0,0,0,0,0,0,0));
      add(NOP(),      E(0,0,0,0,0,0,0));
      while (stq.size() > 0) begin
         drive_a(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_a() !== e) begin n_fail++; $display("FAIL x0 cyc%0d got=%b exp=%b", cyc, got_a(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL x0_stall_cnt got=%0d exp=0", ifa.stall_cycles); end
   endtask

   task automatic test_redirect();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(LW(5, 1),                 E(0,0,0,0,0,0,0));
      add(WITH(R(6, 5, 7), 1, 0),   E(0,0,0,1,1,0,0));
      add(R(10, 6, 6),              E(0,0,0,0,0,0,0));
      add(NOP(),                    E(0,0,0,0,0,0,0));
      while (stq.size() > 0) begin
         drive_a(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_a() !== e) begin n_fail++; $display("FAIL redirect cyc%0d got=%b exp=%b", cyc, got_a(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifa.flush_count !== 16'd1) begin n_fail++; $display("FAIL redirect_flush_cnt got=%0d exp=1", ifa.flush_count); end
      n_tests++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL redirect_stall_cnt got=%0d exp=0", ifa.stall_cycles); end
   endtask

   task automatic test_freeze();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(I(1, 0),                  E(0,0,0,0,0,0,0));
      add(LW(5, 1),                 E(0,0,0,0,0,0,0));
      add(WITH(R(6, 5, 7), 0, 1),   E(1,1,1,0,0,1,0));
      add(WITH(R(6, 5, 7), 1, 1),   E(1,1,1,0,0,1,0));
      add(WITH(R(6, 5, 7), 0, 1),   E(1,1,1,0,0,1,0));
      add(R(6, 5, 7),               E(0,1,1,0,1,1,0));
      add(R(6, 5, 7),               E(0,0,0,0,0,0,0));
      add(NOP(),                    E(0,0,0,0,0,2,0));
      while (stq.size() > 0) begin
         drive_a(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_a() !== e) begin n_fail++; $display("FAIL freeze cyc%0d got=%b exp=%b", cyc, got_a(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifa.stall_cycles !== 16'd4) begin n_fail++; $display("FAIL freeze_stall_cnt got=%0d exp=4", ifa.stall_cycles); end
      n_tests++; if (ifa.flush_count !== 16'd0) begin n_fail++; $display("FAIL freeze_flush_cnt got=%0d exp=0", ifa.flush_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_a(LW(5, 1));
      @(posedge clk); #1;
      drive_a(WITH(R(6, 5, 7), 0, 1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      drive_a(R(6, 5, 7));
      @(negedge clk);
      n_tests++; if (got_a() !== 11'd0) begin n_fail++; $display("FAIL reset_mid_ctl got=%b exp=%b", got_a(), 11'd0); end
      n_tests++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_mid_stall_cnt got=%0d exp=0", ifa.stall_cycles); end
      n_tests++; if (ifa.flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_mid_flush_cnt got=%0d exp=0", ifa.flush_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_deep_pipe();
      int cyc = 0;
      logic [10:0] e;
      do_reset();
      add(LW(5, 1),    E(0,0,0,0,0,0,0));
      add(R(6, 5, 7),  E(0,1,1,0,1,0,0));
      add(R(6, 5, 7),  E(0,1,1,0,1,0,0));
      add(R(6, 5, 7),  E(0,1,1,0,1,0,0));
      add(R(6, 5, 7),  E(0,0,0,0,0,0,0));
      add(NOP(),       E(0,0,0,0,0,4,0));
      while (stq.size() > 0) begin
         drive_b(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_b() !== e) begin n_fail++; $display("FAIL deep_pipe cyc%0d got=%b exp=%b", cyc, got_b(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifb.stall_cycles !== 2'd3) begin n_fail++; $display("FAIL deep_stall_cnt got=%0d exp=3", ifb.stall_cycles); end
      add(WITH(NOP(), 0, 1), E(1,1,1,0,0,0,0));
      add(WITH(NOP(), 0, 1), E(1,1,1,0,0,0,0));
      while (stq.size() > 0) begin
         drive_b(stq.pop_front());
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (got_b() !== e) begin n_fail++; $display("FAIL deep_freeze cyc%0d got=%b exp=%b", cyc, got_b(), e); end
         @(posedge clk); #1; cyc++;
      end
      n_tests++; if (ifb.stall_cycles !== 2'd3) begin n_fail++; $display("FAIL deep_saturate got=%0d exp=3", ifb.stall_cycles); end
      n_tests++; if (ifb.flush_count !== 2'd0) begin n_fail++; $display("FAIL deep_flush_cnt got=%0d exp=0", ifb.flush_count); end
      drive_b(NOP());
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      drive_a(NOP());
      drive_b(NOP());
      test_reset();
      test_load_use();
      test_back_to_back();
      test_x0();
      test_redirect();
      test_freeze();
      test_reset_mid();
      test_deep_pipe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
